trap_monitor: RTL and testbench
===============================

# trap_monitor

Parametrised multi-lane trap monitor at the commit point of the core. Watches up to NCOMMIT retiring instructions per cycle, detects ebreak (good/bad by a0), illegal opcodes and a no-commit watchdog timeout. Latches the first halt event with PC, instruction and cause, and keeps retired-instruction and cycle counters. It is the successor of the single-lane ebreak/illegal checker and feeds both the simulation harness and the difftest halt path.

## Interface
- XLEN, 32, data/PC width
- NCOMMIT, 2, commit lanes per cycle (1..4)
- WDOG_CYCLES, 4096, consecutive idle cycles before a watchdog halt; 0 disables the watchdog
- clk  in  1  clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low
- commit_valid  in  NCOMMIT  lane i retires an instruction this cycle
- commit_pc  in  NCOMMIT*XLEN  lane i PC, lane i at bits [i*XLEN +: XLEN]
- commit_inst  in  NCOMMIT*32  lane i instruction word
- a0  in  XLEN  architectural x10, sampled with the trapping commit
- halt  out  1  sticky, simulation must stop
- good_trap  out  1  halt was ebreak with a0 == 0
- halt_cause  out  2  0 none, 1 ebreak, 2 illegal, 3 watchdog
- halt_pc  out  XLEN  PC of the trapping instruction (last committed PC for watchdog)
- halt_inst  out  32  trapping instruction (0 for watchdog)
- exit_code  out  XLEN  a0 captured at ebreak, else 0
- inst_count  out  64  instructions retired
- cycle_count  out  64  cycles since reset release

## Operation
- FSM states RUN, HALT. Reset enters RUN.
- RUN, per cycle: lanes scanned from index 0 upward. A valid lane is ebreak if inst == 32'h00100073. It is illegal if opcode [6:0] is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM, SYSTEM.
- The lowest valid trapping lane wins. Valid lanes at or below it add to inst_count; lanes above it are discarded. FSM goes to HALT and latches cause/pc/inst, plus a0 for ebreak.
- No trap: inst_count += popcount(commit_valid). Valid lanes need not be contiguous.
- Watchdog counter clears on any valid lane and increments on cycles with none. When it reaches WDOG_CYCLES: HALT with cause 3, halt_pc = last committed PC (0 if none yet).
- cycle_count increments every RUN cycle and freezes in HALT.
- HALT: all inputs ignored, all outputs held until reset. No exit other than reset.
- Counters wrap modulo 2^64.

## Timing
- Reset values: halt 0, good_trap 0, halt_cause 0, halt_pc 0, halt_inst 0, exit_code 0, inst_count 0, cycle_count 0, watchdog 0, state RUN.
- Trap on edge N sets halt and the latched fields visible after edge N (one-cycle latency). inst_count includes the trapping lane in that same update.
- Watchdog: halt rises after the WDOG_CYCLES-th consecutive idle edge.
- A trap and watchdog expiry cannot coincide, since a trap needs a valid lane.
- rst low during RUN or HALT: all state cleared at that edge. rst has priority over every event.

## Configuration
- TRAP_FINISH_EN defined: a simulation-only block prints a GOOD/BAD TRAP banner with cause, PC, instruction, exit code and counters. It does this on the first cycle halt is 1, then calls $finish(0) if good_trap, else $finish(1).
- TRAP_FINISH_EN undefined: no system tasks, fully synthesizable. The harness polls halt.

## Structure
- trap_pkg holds:
  - halt_cause_e enum (NONE, EBREAK, ILLEGAL, WDOG)
  - RV32I opcode localparams
  - EBREAK_INST constant
  - function is_legal_opcode
- Sub-module trap_decode: combinational per-lane classifier (valid, inst → is_ebreak, is_illegal), generated NCOMMIT times.
- trap_monitor holds the FSM, lane priority, counters and watchdog.

## Test plan
- NCOMMIT=2: 10 cycles of both lanes valid with ADDI (32'h00100093), then lane0 ebreak with a0=0 → halt=1, good_trap=1, cause 1, inst_count=21, exit_code=0.
- Lane0 ADDI valid and lane1 inst 32'h0000007F at pc 32'h80000104 → cause 2, halt_pc=32'h80000104, halt_inst=32'h0000007F, inst_count=2.
- Same cycle, lane0 illegal and lane1 ebreak → cause 2 (lane0 wins), lane1 not counted.
- WDOG_CYCLES=16: one commit at pc 32'h80000000, then 16 idle cycles → halt after the 16th idle edge, cause 3, halt_pc=32'h80000000. 15 idle cycles then a commit → no halt.
- Ebreak with a0=5 → good_trap=0, exit_code=5. Further commits do not change inst_count. rst low for one cycle → all outputs 0, state RUN.

Source files
------------

// File: rtl/trap_pkg.sv
// trap_pkg: shared types, RV32I opcode constants and helpers for the trap monitor.
package trap_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        EBREAK  = 2'd1,
        ILLEGAL = 2'd2,
        WDOG    = 2'd3
    } halt_cause_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } trap_state_e;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [31:0] EBREAK_INST = 32'h00100073;

    // True for any base RV32I major opcode; everything else is treated as illegal.
    function automatic logic is_legal_opcode(input logic [6:0] opc);
        logic legal;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
            OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP,
            OPC_MISC_MEM, OPC_SYSTEM: legal = 1'b1;
            default:                  legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage

// File: rtl/trap_decode.sv
// trap_decode: classifies one commit lane as ebreak and/or illegal instruction.
module trap_decode
    import trap_pkg::*;
(
    input  logic        valid,
    input  logic [31:0] inst,
    output logic        is_ebreak,
    output logic        is_illegal
);

    // A lane only flags a trap when it actually retires; idle lanes carry stale words.
    always_comb begin
        is_ebreak  = 1'b0;
        is_illegal = 1'b0;
        if (valid) begin
            is_ebreak  = (inst == EBREAK_INST);
            is_illegal = !is_legal_opcode(inst[6:0]);
        end
    end

endmodule

// File: rtl/trap_monitor.sv
// trap_monitor: multi-lane commit-point trap monitor with halt latch, counters
// and a no-commit watchdog. Optional TRAP_FINISH_EN adds a simulation-only
// banner that ends the run when halt first rises.
module trap_monitor
    import trap_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int NCOMMIT     = 2,
    parameter int WDOG_CYCLES = 4096
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NCOMMIT-1:0]      commit_valid,
    input  logic [NCOMMIT*XLEN-1:0] commit_pc,
    input  logic [NCOMMIT*32-1:0]   commit_inst,
    input  logic [XLEN-1:0]         a0,
    output logic                    halt,
    output logic                    good_trap,
    output logic [1:0]              halt_cause,
    output logic [XLEN-1:0]         halt_pc,
    output logic [31:0]             halt_inst,
    output logic [XLEN-1:0]         exit_code,
    output logic [63:0]             inst_count,
    output logic [63:0]             cycle_count
);

    localparam int WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES + 1) : 1;
    localparam int RET_W  = 3;
    localparam logic [WDOG_W-1:0] WDOG_LAST =
        (WDOG_CYCLES > 0) ? WDOG_W'(WDOG_CYCLES - 1) : '0;

    trap_state_e       state;
    trap_state_e       state_next;
    halt_cause_e       cause_q;

    logic [NCOMMIT-1:0] lane_ebreak;
    logic [NCOMMIT-1:0] lane_illegal;

    logic              any_valid;
    logic              trap_hit;
    logic              trap_ebreak;
    logic [XLEN-1:0]   trap_pc;
    logic [31:0]       trap_inst;
    logic [RET_W-1:0]  retire_cnt;
    logic [XLEN-1:0]   scan_last_pc;
    logic [XLEN-1:0]   last_pc;
    logic [WDOG_W-1:0] wdog_cnt;
    logic              wdog_expire;

    genvar g;
    generate
        for (g = 0; g < NCOMMIT; g++) begin : g_lane
            trap_decode u_decode (
                .valid      (commit_valid[g]),
                .inst       (commit_inst[g*32 +: 32]),
                .is_ebreak  (lane_ebreak[g]),
                .is_illegal (lane_illegal[g])
            );
        end
    endgenerate

    assign any_valid = |commit_valid;

    // Scan lanes from 0 upward: count retirements up to and including the first trap.
    always_comb begin
        trap_hit     = 1'b0;
        trap_ebreak  = 1'b0;
        trap_pc      = '0;
        trap_inst    = '0;
        retire_cnt   = '0;
        scan_last_pc = last_pc;
        for (int i = 0; i < NCOMMIT; i++) begin
            if (!trap_hit && commit_valid[i]) begin
                retire_cnt   = retire_cnt + RET_W'(1);
                scan_last_pc = commit_pc[i*XLEN +: XLEN];
                if (lane_ebreak[i] || lane_illegal[i]) begin
                    trap_hit    = 1'b1;
                    trap_ebreak = lane_ebreak[i];
                    trap_pc     = commit_pc[i*XLEN +: XLEN];
                    trap_inst   = commit_inst[i*32 +: 32];
                end
            end
        end
    end

    // The watchdog fires on the idle cycle that would make the count reach the limit.
    always_comb begin
        wdog_expire = 1'b0;
        if ((WDOG_CYCLES != 0) && !any_valid) begin
            wdog_expire = (wdog_cnt == WDOG_LAST);
        end
    end

    // Next-state: RUN leaves only on a trap or watchdog; HALT is left only by reset.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (trap_hit || wdog_expire) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Counters and watchdog advance only while running so they freeze at halt.
    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_count  <= '0;
            cycle_count <= '0;
            last_pc     <= '0;
            wdog_cnt    <= '0;
        end else if (state == RUN) begin
            cycle_count <= cycle_count + 64'd1;
            inst_count  <= inst_count + 64'(retire_cnt);
            last_pc     <= scan_last_pc;
            if (any_valid) begin
                wdog_cnt <= '0;
            end else if (WDOG_CYCLES != 0) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
        end
    end

    // Latch the first halt event; nothing is written again until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cause_q   <= NONE;
            good_trap <= 1'b0;
            halt_pc   <= '0;
            halt_inst <= '0;
            exit_code <= '0;
        end else if (state == RUN) begin
            if (trap_hit) begin
                cause_q   <= trap_ebreak ? EBREAK : ILLEGAL;
                good_trap <= trap_ebreak && (a0 == '0);
                halt_pc   <= trap_pc;
                halt_inst <= trap_inst;
                exit_code <= trap_ebreak ? a0 : '0;
            end else if (wdog_expire) begin
                cause_q   <= WDOG;
                good_trap <= 1'b0;
                halt_pc   <= last_pc;
                halt_inst <= '0;
                exit_code <= '0;
            end
        end
    end

    assign halt       = (state == HALT);
    assign halt_cause = cause_q;

`ifdef TRAP_FINISH_EN
    logic banner_done;

    // Print the halt banner once and end the simulation with a pass/fail status.
    always_ff @(posedge clk) begin
        if (!rst) begin
            banner_done <= 1'b0;
        end else if (halt && !banner_done) begin
            banner_done <= 1'b1;
            $display("%s TRAP: cause=%0d pc=%h inst=%h exit=%0d insts=%0d cycles=%0d",
                     good_trap ? "GOOD" : "BAD", halt_cause, halt_pc, halt_inst,
                     exit_code, inst_count, cycle_count);
            if (good_trap) $finish(0);
            else           $finish(1);
        end
    end
`else
    // Synthesizable build: the harness polls halt and reads the latched fields.
`endif

endmodule

// File: tb/tb_trap_monitor.sv
// tb_trap_monitor: directed scoreboard bench for trap_monitor (NCOMMIT=2, WDOG_CYCLES=16).
module tb_trap_monitor;

    localparam int XLEN = 32;
    localparam int NC   = 2;
    localparam int WDOG = 16;

    localparam logic [31:0] ADDI  = 32'h00100093;
    localparam logic [31:0] EBRK  = 32'h00100073;
    localparam logic [31:0] BADOP = 32'h0000007F;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NC-1:0]        commit_valid = '0;
    logic [NC*XLEN-1:0]   commit_pc = '0;
    logic [NC*32-1:0]     commit_inst = '0;
    logic [XLEN-1:0]      a0 = '0;
    logic                 halt;
    logic                 good_trap;
    logic [1:0]           halt_cause;
    logic [XLEN-1:0]      halt_pc;
    logic [31:0]          halt_inst;
    logic [XLEN-1:0]      exit_code;
    logic [63:0]          inst_count;
    logic [63:0]          cycle_count;

    typedef struct {
        logic [1:0]  cause;
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] exit_code;
        logic        good;
        logic [63:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic        m_halted;
    logic [63:0] m_inst;
    logic [63:0] m_cycle;
    logic [31:0] m_last_pc;
    int          m_idle;
    logic        prev_halt;

    trap_monitor #(.XLEN(XLEN), .NCOMMIT(NC), .WDOG_CYCLES(WDOG)) dut (
        .clk          (clk),
        .rst          (rst),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .a0           (a0),
        .halt         (halt),
        .good_trap    (good_trap),
        .halt_cause   (halt_cause),
        .halt_pc      (halt_pc),
        .halt_inst    (halt_inst),
        .exit_code    (exit_code),
        .inst_count   (inst_count),
        .cycle_count  (cycle_count)
    );

    always #5 clk = ~clk;

    function automatic bit tb_legal(input logic [6:0] o);
        return o inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                         7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyReset(input int cycles);
        commit_valid = '0;
        commit_pc    = '0;
        commit_inst  = '0;
        a0           = '0;
        rst          = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        chk("reset.sb_drained", 64'(sb.size()), 64'd0);
        sb.delete();
        m_halted  = 1'b0;
        m_inst    = '0;
        m_cycle   = '0;
        m_last_pc = '0;
        m_idle    = 0;
        prev_halt = 1'b0;
        chk("reset.halt",   64'(halt),       64'd0);
        chk("reset.good",   64'(good_trap),  64'd0);
        chk("reset.cause",  64'(halt_cause), 64'd0);
        chk("reset.pc",     64'(halt_pc),    64'd0);
        chk("reset.inst",   64'(halt_inst),  64'd0);
        chk("reset.exit",   64'(exit_code),  64'd0);
        chk("reset.icount", inst_count,      64'd0);
        chk("reset.cycles", cycle_count,     64'd0);
        rst = 1'b1;
    endtask

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [31:0] p0, input logic [31:0] i0,
                                 input logic [31:0] p1, input logic [31:0] i1,
                                 input logic [31:0] a);
        logic [31:0] pcs[2];
        logic [31:0] ins[2];
        bit          found;
        exp_t        e;
        pcs[0] = p0; pcs[1] = p1;
        ins[0] = i0; ins[1] = i1;
        commit_valid = v;
        commit_pc    = {p1, p0};
        commit_inst  = {i1, i0};
        a0           = a;
        found        = 1'b0;
        if (!m_halted) begin
            m_cycle = m_cycle + 64'd1;
            for (int l = 0; l < 2; l++) begin
                if (!found && v[l]) begin
                    m_inst    = m_inst + 64'd1;
                    m_last_pc = pcs[l];
                    if (ins[l] == EBRK) begin
                        found = 1'b1;
                        e = '{cause: 2'd1, pc: pcs[l], inst: ins[l], exit_code: a,
                              good: (a == 32'd0), cnt: m_inst};
                        sb.push_back(e);
                    end else if (!tb_legal(ins[l][6:0])) begin
                        found = 1'b1;
                        e = '{cause: 2'd2, pc: pcs[l], inst: ins[l], exit_code: 32'd0,
                              good: 1'b0, cnt: m_inst};
                        sb.push_back(e);
                    end
                end
            end
            if (found) begin
                m_halted = 1'b1;
            end else if (v == 2'b00) begin
                m_idle++;
                if (m_idle == WDOG) begin
                    e = '{cause: 2'd3, pc: m_last_pc, inst: 32'd0, exit_code: 32'd0,
                          good: 1'b0, cnt: m_inst};
                    sb.push_back(e);
                    m_halted = 1'b1;
                end
            end else begin
                m_idle = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        chk({tag, ".halt"},   64'(halt),   64'(m_halted));
        chk({tag, ".icount"}, inst_count,  m_inst);
        chk({tag, ".cycles"}, cycle_count, m_cycle);
        if (halt && !prev_halt) begin
            n_checks++;
            assert (sb.size() != 0) else begin
                n_errors++;
                $error("[TB] FAIL %s.sb: got halt with 0 pending expected 1 pending", tag);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk({tag, ".cause"}, 64'(halt_cause), 64'(e.cause));
                chk({tag, ".pc"},    64'(halt_pc),    64'(e.pc));
                chk({tag, ".inst"},  64'(halt_inst),  64'(e.inst));
                chk({tag, ".exit"},  64'(exit_code),  64'(e.exit_code));
                chk({tag, ".good"},  64'(good_trap),  64'(e.good));
                chk({tag, ".cnt"},   inst_count,      e.cnt);
            end
        end
        prev_halt = halt;
    endtask

    initial begin
        $display("[TB] trap_monitor directed test start");
        applyReset(2);

        // Ten dual-lane ADDI cycles, then a good ebreak on lane 0.
        for (int k = 0; k < 10; k++) begin
            applyStimulus(2'b11, 32'h80000000 + 32'(8 * k), ADDI,
                          32'h80000004 + 32'(8 * k), ADDI, 32'd0);
            checkOutput("A.run");
        end
        applyStimulus(2'b11, 32'h80000050, EBRK, 32'h80000054, ADDI, 32'd0);
        checkOutput("A.trap");
        chk("A.halt1",  64'(halt),       64'd1);
        chk("A.good1",  64'(good_trap),  64'd1);
        chk("A.cause1", 64'(halt_cause), 64'd1);
        chk("A.cnt21",  inst_count,      64'd21);
        chk("A.exit0",  64'(exit_code),  64'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(2'b11, 32'h80000100, ADDI, 32'h80000104, BADOP, 32'd7);
            checkOutput("A.held");
        end
        chk("A.held_cause", 64'(halt_cause), 64'd1);
        chk("A.held_pc",    64'(halt_pc),    64'h80000050);

        // Illegal opcode on lane 1 after a legal lane 0.
        applyReset(1);
        applyStimulus(2'b11, 32'h80000100, ADDI, 32'h80000104, BADOP, 32'd0);
        checkOutput("B.trap");
        chk("B.cause2", 64'(halt_cause), 64'd2);
        chk("B.pc",     64'(halt_pc),    64'h80000104);
        chk("B.inst",   64'(halt_inst),  64'h0000007F);
        chk("B.cnt2",   inst_count,      64'd2);

        // Lane 0 illegal beats lane 1 ebreak; lane 1 is discarded.
        applyReset(1);
        applyStimulus(2'b11, 32'h80000200, BADOP, 32'h80000204, EBRK, 32'd0);
        checkOutput("C.trap");
        chk("C.cause2", 64'(halt_cause), 64'd2);
        chk("C.cnt1",   inst_count,      64'd1);

        // Fifteen idle cycles then a commit must not halt.
        applyReset(1);
        applyStimulus(2'b01, 32'h80000000, ADDI, 32'h0, 32'h0, 32'd0);
        checkOutput("W1.commit");
        for (int k = 0; k < 15; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
            checkOutput("W1.idle");
        end
        applyStimulus(2'b10, 32'h0, 32'h0, 32'h80000010, ADDI, 32'd0);
        checkOutput("W1.commit2");
        chk("W1.nohalt", 64'(halt), 64'd0);

        // Sixteen idle cycles after one commit trip the watchdog.
        applyReset(1);
        applyStimulus(2'b01, 32'h80000000, ADDI, 32'h0, 32'h0, 32'd0);
        checkOutput("W2.commit");
        for (int k = 0; k < 16; k++) begin
            applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 32'd0);
            checkOutput("W2.idle");
        end
        chk("W2.cause3", 64'(halt_cause), 64'd3);
        chk("W2.pc",     64'(halt_pc),    64'h80000000);
        chk("W2.inst0",  64'(halt_inst),  64'd0);

        // Bad ebreak (a0=5) on lane 1 with an idle illegal word on lane 0.
        applyReset(1);
        applyStimulus(2'b10, 32'h80000300, BADOP, 32'h80000304, EBRK, 32'd5);
        checkOutput("E.trap");
        chk("E.good0", 64'(good_trap), 64'd0);
        chk("E.exit5", 64'(exit_code), 64'd5);
        chk("E.cnt1",  inst_count,     64'd1);
        for (int k = 0; k < 2; k++) begin
            applyStimulus(2'b11, 32'h80000308, ADDI, 32'h8000030C, ADDI, 32'd0);
            checkOutput("E.held");
        end
        chk("E.cnt_frozen", inst_count, 64'd1);
        applyReset(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
